lcd_bus_writer: RTL and testbench

LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

---
 rtl/lcd_bus_writer.sv | 145 ++++++++++++++
 tb/tb_lcd_bus_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// HD44780-style LCD write sequencer: power-up wait, then one byte per handshake with
// RS/data setup, enable pulse, hold and a command-dependent execution wait.
module lcd_bus_writer #(
  parameter int POWERON_CYC   = 5400000,
  parameter int SETUP_CYC     = 4,
  parameter int PULSE_CYC     = 27,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2700,
  parameter int LONG_EXEC_CYC = 108000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    PWRON = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    EXEC  = 3'd5
  } state_t;

  // Terminal count of the up-counting phase counter; zero-length phases behave as one cycle.
  function automatic logic [22:0] last_count(input int cyc);
    if (cyc <= 1) begin
      return 23'd0;
    end else begin
      return 23'(cyc - 1);
    end
  endfunction

  // Clear display / return home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  localparam logic [22:0] PWRON_LAST = last_count(POWERON_CYC);
  localparam logic [22:0] SETUP_LAST = last_count(SETUP_CYC);
  localparam logic [22:0] PULSE_LAST = last_count(PULSE_CYC);
  localparam logic [22:0] HOLD_LAST  = last_count(HOLD_CYC);
  localparam logic [22:0] EXEC_LAST  = last_count(EXEC_CYC);
  localparam logic [22:0] LONG_LAST  = last_count(LONG_EXEC_CYC);

  state_t      state_r;
  logic [22:0] cnt_r;
  logic [22:0] phase_last_s;
  logic        phase_end_s;

  // Select the terminal count for the current phase.
  always_comb begin
    phase_last_s = 23'd0;
    case (state_r)
      PWRON:   phase_last_s = PWRON_LAST;
      IDLE:    phase_last_s = 23'd0;
      SETUP:   phase_last_s = SETUP_LAST;
      PULSE:   phase_last_s = PULSE_LAST;
      HOLD:    phase_last_s = HOLD_LAST;
      EXEC:    phase_last_s = is_long_cmd(lcd_rs, lcd_data) ? LONG_LAST : EXEC_LAST;
      default: phase_last_s = 23'd0;
    endcase
    phase_end_s = (cnt_r == phase_last_s);
  end

  // Sequencer state, shared phase counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= PWRON;
      cnt_r    <= 23'd0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rw   <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      lcd_rw <= 1'b0;
      done   <= 1'b0;
      // Counter restarts from zero on every state entry; IDLE holds it at zero.
      cnt_r  <= phase_end_s ? 23'd0 : (cnt_r + 23'd1);
      case (state_r)
        PWRON: begin
          if (phase_end_s) begin
            state_r  <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        IDLE: begin
          if (in_valid) begin
            state_r  <= SETUP;
            lcd_rs   <= in_rs;
            lcd_data <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (phase_end_s) begin
            state_r <= PULSE;
            lcd_en  <= 1'b1;
          end
        end
        PULSE: begin
          if (phase_end_s) begin
            state_r <= HOLD;
            lcd_en  <= 1'b0;
          end
        end
        HOLD: begin
          if (phase_end_s) begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          if (phase_end_s) begin
            state_r  <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state_r  <= PWRON;
          cnt_r    <= 23'd0;
          lcd_en   <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: stimulus queues expected writes, a negedge
// monitor checks each enable pulse, busy window and done pulse against them.
module tb_lcd_bus_writer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       busy;
  logic       done;

  lcd_bus_writer #(
    .POWERON_CYC  (10),
    .SETUP_CYC    (2),
    .PULSE_CYC    (4),
    .HOLD_CYC     (2),
    .EXEC_CYC     (8),
    .LONG_EXEC_CYC(20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs   (in_rs),
    .in_data (in_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en),
    .lcd_data(lcd_data),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_len;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur    = 1'b0;
  bit   mon_en      = 1'b0;
  int   checks      = 0;
  int   passed      = 0;
  int   n_writes    = 0;
  int   done_total  = 0;
  int   low_cnt     = 0;
  int   en_width    = 0;
  int   done_w      = 0;
  logic en_prev     = 1'b0;
  logic rdy_prev    = 1'b0;
  logic done_prev   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte and keep in_valid up until the DUT accepts it.
  task automatic send(input logic rs, input logic [7:0] d, input int blen,
                      input bit hold, input bit expect_it);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    if (expect_it) begin
      exp_q.push_back('{rs, d, blen});
      n_writes++;
    end
    for (int i = 0; i < 200 && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
      @(negedge clk);
      if (expect_it) begin
        check("bus_rs_after_accept", {31'd0, lcd_rs}, {31'd0, rs});
        check("bus_data_after_accept", {24'd0, lcd_data}, {24'd0, d});
      end
    end
  endtask

  task automatic wait_idle();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (in_ready) found = 1'b1;
    end
    if (!found) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Count cycles from the current negedge until in_ready is seen high.
  task automatic count_to_ready(output int n);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
      check("en_low_in_pwron", {31'd0, lcd_en}, 32'd0);
    end
  endtask

  // Monitor: pops the scoreboard on each enable pulse and checks timing.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_ready) low_cnt++;
      if (lcd_en && !en_prev) begin
        en_width = 1;
        if (mon_en) begin
          check("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            check("pulse_rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
            check("pulse_data", {24'd0, lcd_data}, {24'd0, cur.data});
            check("en_start_cycle", low_cnt, 32'd3);
          end
        end
      end else if (lcd_en) begin
        en_width++;
      end
      if (!lcd_en && en_prev && mon_en) check("en_width", en_width, 32'd4);
      if (in_ready && !rdy_prev && mon_en && have_cur) begin
        check("busy_len", low_cnt, cur.busy_len);
        check("done_at_ready", {31'd0, done}, 32'd1);
        check("data_held", {24'd0, lcd_data}, {24'd0, cur.data});
        check("rs_held", {31'd0, lcd_rs}, {31'd0, cur.rs});
        check("busy_inverse", {31'd0, busy}, 32'd0);
        have_cur = 1'b0;
      end
      if (in_ready) low_cnt = 0;
      if (done) begin
        done_w++;
        done_total++;
      end
      if (!done && done_prev && mon_en) check("done_width", done_w, 32'd1);
      if (!done) done_w = 0;
      en_prev   = lcd_en;
      rdy_prev  = in_ready;
      done_prev = done;
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_lcd_en", {31'd0, lcd_en}, 32'd0);
    check("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    count_to_ready(n);
    check("poweron_cycles", n, 32'd10);
    mon_en = 1'b1;

    // Single data write, then command length boundaries.
    send(1'b1, 8'h4B, 16, 1'b0, 1'b1); wait_idle();
    send(1'b0, 8'h01, 28, 1'b0, 1'b1); wait_idle();
    send(1'b1, 8'h01, 16, 1'b0, 1'b1); wait_idle();
    send(1'b0, 8'h02, 28, 1'b0, 1'b1); wait_idle();
    send(1'b0, 8'h03, 28, 1'b0, 1'b1); wait_idle();
    send(1'b0, 8'h04, 16, 1'b0, 1'b1); wait_idle();

    // Back-to-back with in_valid held high.
    send(1'b1, 8'h41, 16, 1'b1, 1'b1);
    send(1'b1, 8'h42, 16, 1'b1, 1'b1);
    send(1'b1, 8'h43, 16, 1'b0, 1'b1);
    wait_idle();

    // Input noise while busy must not disturb the bus.
    send(1'b0, 8'h80, 16, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!in_ready) begin
        in_valid = ~in_valid;
        in_rs    = ~in_rs;
        in_data  = in_data ^ 8'hFF;
      end
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset during the enable pulse.
    mon_en   = 1'b0;
    have_cur = 1'b0;
    send(1'b1, 8'h55, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !lcd_en; i++) @(negedge clk);
    check("reached_pulse", {31'd0, lcd_en}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_lcd_en", {31'd0, lcd_en}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("midrst_lcd_data", {24'd0, lcd_data}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    count_to_ready(n);
    check("poweron_after_midrst", n, 32'd10);
    mon_en = 1'b1;

    send(1'b0, 8'h38, 16, 1'b0, 1'b1); wait_idle();

    check("done_total", done_total, n_writes);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
